// File: rtl/rr_job_dispatcher_if.sv
// Handshake bundle between the requester agents, the round-robin dispatcher
// and the shared single-job processing unit.
interface rr_job_dispatcher_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] ack;
  logic               unit_start;
  logic               unit_done;
  logic               busy;
  logic               timeout_err;

  // Requester/unit side: drives requests and completion, observes the dispatcher.
  modport master (
    output req,
    output unit_done,
    input  grant,
    input  grant_id,
    input  ack,
    input  unit_start,
    input  busy,
    input  timeout_err
  );

  // Dispatcher side.
  modport slave (
    input  req,
    input  unit_done,
    output grant,
    output grant_id,
    output ack,
    output unit_start,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/rr_job_dispatcher.sv
// Round-robin dispatcher sharing one start/done processing unit among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining RR_JOB_DISPATCHER_TIMEOUT_EN.
module rr_job_dispatcher #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  rr_job_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  if ((NUM_REQ < 2) || (NUM_REQ > 16) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("rr_job_dispatcher: parameter out of range");
  end

  state_t             state_r;
  state_t             state_s;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_id_r;
  logic [ID_W-1:0]    grant_id_s;
  logic [ID_W-1:0]    ptr_r;
  logic [ID_W-1:0]    ptr_s;
  logic [NUM_REQ-1:0] mask_r;
  logic [NUM_REQ-1:0] mask_s;
  logic [NUM_REQ-1:0] ack_r;
  logic [NUM_REQ-1:0] ack_s;
  logic               start_r;
  logic               start_s;
  logic               busy_r;
  logic               busy_s;
  logic               tmo_r;
  logic               tmo_s;
  logic               timeout_s;
  logic               wdog_limit_s;

  logic [NUM_REQ-1:0] cand_s;
  logic               pick_found_s;
  logic [ID_W-1:0]    pick_id_s;
  logic [NUM_REQ-1:0] pick_onehot_s;
  int                 dist_s;
  int                 best_s;

  assign cand_s        = bus.req & ~mask_r;
  assign pick_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id_s;

  // Round-robin pick: smallest distance from ptr+1 (mod NUM_REQ) among candidates.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    best_s       = NUM_REQ;
    dist_s       = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      dist_s = (j + NUM_REQ - 1 - int'(ptr_r)) % NUM_REQ;
      if (cand_s[j] && (dist_s < best_s)) begin
        best_s       = dist_s;
        pick_id_s    = ID_W'(j);
        pick_found_s = 1'b1;
      end else begin
        best_s       = best_s;
      end
    end
  end

`ifdef RR_JOB_DISPATCHER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_r;

  // Watchdog: cleared while issuing, counts WAIT cycles that lack unit_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_r <= '0;
    end else if (state_r == ST_ISSUE) begin
      wdog_r <= '0;
    end else if ((state_r == ST_WAIT) && !bus.unit_done) begin
      wdog_r <= wdog_r + WD_W'(1);
    end else begin
      wdog_r <= wdog_r;
    end
  end

  // The abort lands on the cycle where the count would reach TIMEOUT_CYCLES.
  assign wdog_limit_s = (wdog_r == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_limit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; unit_done is only looked at in WAIT.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.unit_done) begin
          state_s = ST_RELEASE;
        end else if (wdog_limit_s) begin
          state_s   = ST_RELEASE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RELEASE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output next values, registered below so every port comes from a flop.
  always_comb begin
    grant_s    = grant_r;
    grant_id_s = grant_id_r;
    ack_s      = '0;
    start_s    = 1'b0;
    busy_s     = (state_s != ST_IDLE);
    tmo_s      = timeout_s;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_s    = pick_onehot_s;
          grant_id_s = pick_id_s;
          start_s    = 1'b1;
        end else begin
          grant_s    = '0;
          grant_id_s = '0;
        end
      end
      ST_ISSUE: begin
        grant_s = grant_r;
      end
      ST_WAIT: begin
        if (state_s == ST_RELEASE) begin
          ack_s = grant_r;
        end else begin
          ack_s = '0;
        end
      end
      ST_RELEASE: begin
        grant_s    = '0;
        grant_id_s = '0;
      end
      default: begin
        grant_s    = '0;
        grant_id_s = '0;
      end
    endcase
  end

  // Pointer and one-cycle mask of the requester just acknowledged.
  always_comb begin
    ptr_s  = ptr_r;
    mask_s = '0;
    if (state_r == ST_RELEASE) begin
      ptr_s  = grant_id_r;
      mask_s = grant_r;
    end else begin
      ptr_s  = ptr_r;
    end
  end

  // Output and arbitration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_r    <= '0;
      grant_id_r <= '0;
      ack_r      <= '0;
      start_r    <= 1'b0;
      busy_r     <= 1'b0;
      tmo_r      <= 1'b0;
      ptr_r      <= ID_W'(NUM_REQ - 1);
      mask_r     <= '0;
    end else begin
      grant_r    <= grant_s;
      grant_id_r <= grant_id_s;
      ack_r      <= ack_s;
      start_r    <= start_s;
      busy_r     <= busy_s;
      tmo_r      <= tmo_s;
      ptr_r      <= ptr_s;
      mask_r     <= mask_s;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_id    = grant_id_r;
  assign bus.ack         = ack_r;
  assign bus.unit_start  = start_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = tmo_r;

endmodule

// File: tb/tb_rr_job_dispatcher.sv
// Directed, table-driven bench for rr_job_dispatcher (NUM_REQ=4), plus hand-written
// sequences for mid-job reset and the WAIT watchdog.
module tb_rr_job_dispatcher;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  rr_job_dispatcher_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  rr_job_dispatcher #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] e_grant;
    logic [1:0] e_id;
    logic [3:0] e_ack;
    logic       e_start;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] oh(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return one << k;
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic d, input logic [3:0] g,
                     input logic [1:0] id, input logic [3:0] a, input logic st, input logic bz);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.e_grant = g; v.e_id = id;
    v.e_ack = a; v.e_start = st; v.e_busy = bz;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [3:0] g, input logic [1:0] id,
                            input logic [3:0] a, input logic st, input logic bz, input logic tmo);
    chk({tag, ".grant"},       idx, 32'(bus.grant),       32'(g));
    chk({tag, ".grant_id"},    idx, 32'(bus.grant_id),    32'(id));
    chk({tag, ".ack"},         idx, 32'(bus.ack),         32'(a));
    chk({tag, ".unit_start"},  idx, 32'(bus.unit_start),  32'(st));
    chk({tag, ".busy"},        idx, 32'(bus.busy),        32'(bz));
    chk({tag, ".timeout_err"}, idx, 32'(bus.timeout_err), 32'(tmo));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.unit_done = 1'b0;
    #1;
    check_outs("rst_assert", 0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("rst_hold", 0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got timeout, expected $finish");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req = 4'b0000;
    bus.unit_done = 1'b0;

    // Idle after reset, then a single job from requester 2 with ack masking.
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0100, 1'b0, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);

    // All four requesting: order 0,1,2,3,0; done held high across ISSUE and after ack.
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, 4'b1111, 1'b0, oh(k), 2'(k), 4'b0000, 1'b1, 1'b1);
      add(1'b0, 4'b1111, 1'b0, oh(k), 2'(k), 4'b0000, 1'b0, 1'b1);
      add(1'b0, 4'b1111, 1'b1, oh(k), 2'(k), 4'b0000, 1'b0, 1'b1);
      add(1'b0, 4'b1111, 1'b0, oh(k), 2'(k), oh(k),   1'b0, 1'b1);
      add(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    end
    add(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b1);
    add(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);

    // Owner 3 finishes, then req=1001 wraps to 0, then 3; requester 0 drops req mid-job.
    add(1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 4'b0000, 1'b1, 1'b1);
    add(1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b1000, 2'd3, 4'b1000, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b1001, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b1000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b1);
    add(1'b0, 4'b1000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b1000, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b1000, 1'b0, 4'b0001, 2'd0, 4'b0001, 1'b0, 1'b1);
    add(1'b0, 4'b1000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 4'b0000, 1'b1, 1'b1);
    add(1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b1000, 2'd3, 4'b1000, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      @(negedge clk);
      check_outs("vec", i, tbl[i].e_grant, tbl[i].e_id, tbl[i].e_ack, tbl[i].e_start, tbl[i].e_busy, 1'b0);
      chk("vec.onehot0", i, 32'($onehot0(bus.grant)), 32'd1);
      bus.req = tbl[i].req;
      bus.unit_done = tbl[i].done;
    end

    // Reset asserted while requester 1 is in WAIT.
    do_reset();
    @(negedge clk);
    bus.req = 4'b0010;
    @(negedge clk);
    check_outs("mid_issue", 0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("mid_wait", 0, 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 check_outs("mid_rst", 0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b0011;
    @(negedge clk);
    check_outs("post_rst_issue", 0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("post_rst_wait", 0, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    bus.unit_done = 1'b1;
    @(negedge clk);
    check_outs("post_rst_rel", 0, 4'b0001, 2'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
    bus.unit_done = 1'b0;
    bus.req = 4'b0000;
    @(negedge clk);
    check_outs("post_rst_idle", 0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Unit never completes: watchdog abort 16 cycles after WAIT entry, or wait forever.
    do_reset();
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    check_outs("tmo_issue", 0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check_outs("tmo_wait", k, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
`ifdef RR_JOB_DISPATCHER_TIMEOUT_EN
    check_outs("tmo_abort", 17, 4'b0001, 2'd0, 4'b0001, 1'b0, 1'b1, 1'b1);
    bus.req = 4'b0000;
    @(negedge clk);
    check_outs("tmo_idle", 18, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
`else
    check_outs("tmo_none", 17, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    for (int k = 18; k < 40; k++) begin
      @(negedge clk);
      check_outs("tmo_none", k, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
